// File: rtl/exec_pkg.sv
// exec_pkg: opcode, ALU select and FSM state encodings shared by the controller and the ALU
package exec_pkg;
  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } opcode_t;
  typedef enum logic [1:0] {
    ALU_SUM = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10
  } alu_sel_t;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_t;
  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction
  function automatic logic [15:0] sext10(input logic [9:0] v);
    return {{6{v[9]}}, v};
  endfunction
endpackage

// File: rtl/exec_if.sv
// exec_if: instruction, ALU and writeback/display signals of the execution controller
interface exec_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_data1;
  logic [15:0] alu_data2;
  logic [1:0]  alu_sel;
  logic [15:0] alu_result;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        disp_valid;
  logic [15:0] disp_data;
  logic        busy;
  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_data1, alu_data2, alu_sel, wb_valid, wb_addr, wb_data,
           disp_valid, disp_data, busy
  );
  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_data1, alu_data2, alu_sel, wb_valid, wb_addr, wb_data,
           disp_valid, disp_data, busy
  );
endinterface

// File: rtl/exec_regfile.sv
// exec_regfile: 8x16 register file, two async read ports, one sync write port, sync clear-all
module exec_regfile #(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr1,
  input  logic [2:0]  raddr2,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2
);
  logic [15:0] regs [NREGS];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
  always_ff @(posedge clk)
    if (rst || clr)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (we)
      regs[waddr] <= wdata;
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: four-state instruction controller feeding an external ALU and writing back results
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int NREGS = 8
) (
  input logic   clk,
  input logic   rst,
  exec_if.slave bus
);
  state_t      state, state_nx;
  opcode_t     op;
  alu_sel_t    sel_q, sel_nx;
  logic [15:0] ir, result, disp_q, a_q, b_q, a_nx, b_nx, rdata1, rdata2;
  logic        accept, in_write;
  assign accept   = bus.instr_valid && state == IDLE;
  assign op       = opcode_t'(ir[15:13]);
  assign in_write = state == WRITE;
  always_comb begin
    state_nx = state == IDLE ? (bus.instr_valid ? READ : IDLE) :
               state == READ ? EXEC : state == EXEC ? WRITE : IDLE;
    a_nx     = op == OP_LOAD ? '0 : rdata1;
    b_nx     = op == OP_LOAD ? sext10(ir[9:0]) :
               (op == OP_ADDI || op == OP_SUBI) ? sext7(ir[6:0]) : rdata2;
    sel_nx   = (op == OP_SUB || op == OP_SUBI) ? ALU_SUB : op == OP_MUL ? ALU_MUL : ALU_SUM;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // Operands are sampled in READ, so a WRITE to rd never disturbs the values in use.
  always_ff @(posedge clk)
    if (rst) begin
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= ALU_SUM;
      result <= '0;
      disp_q <= '0;
    end else begin
      if (accept) ir <= bus.instr;
      if (state == READ) begin
        a_q   <= a_nx;
        b_q   <= b_nx;
        sel_q <= sel_nx;
        if (op == OP_DISPLAY) disp_q <= rdata1;
      end
      if (state == EXEC) result <= op == OP_CLEAR ? '0 : bus.alu_result;
    end
  exec_regfile #(.NREGS(NREGS)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .clr   (in_write && op == OP_CLEAR),
    .we    (in_write && op != OP_CLEAR && op != OP_DISPLAY),
    .waddr (ir[12:10]),
    .wdata (result),
    .raddr1(ir[9:7]),
    .raddr2(ir[6:4]),
    .rdata1(rdata1),
    .rdata2(rdata2)
  );
  assign bus.instr_ready = state == IDLE;
  assign bus.busy        = state != IDLE;
  assign bus.alu_data1   = a_q;
  assign bus.alu_data2   = b_q;
  assign bus.alu_sel     = sel_q;
  assign bus.wb_valid    = in_write && op != OP_DISPLAY;
  assign bus.wb_addr     = ir[12:10];
  assign bus.wb_data     = result;
  assign bus.disp_valid  = in_write && op == OP_DISPLAY;
  assign bus.disp_data   = disp_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: randomized scoreboard bench with a behavioural register-machine model
module tb_exec_ctrl;
  typedef struct {
    bit          disp;
    bit          chk_ops;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sel;
    int          cyc;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int cnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] R [8];
  exp_t q [$];
  exp_t me;
  always #5 clk = ~clk;
  exec_if bus();
  exec_ctrl #(.NREGS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always_comb
    bus.alu_result = bus.alu_sel == 2'd0 ? bus.alu_data1 + bus.alu_data2 :
                     bus.alu_sel == 2'd1 ? bus.alu_data1 - bus.alu_data2 :
                     bus.alu_data1 * bus.alu_data2;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  function automatic logic [15:0] ld(input int rd, input int imm);
    return {3'd0, 3'(rd), 10'(imm)};
  endfunction
  function automatic logic [15:0] rr(input int op, input int rd, input int s1, input int s2);
    return {3'(op), 3'(rd), 3'(s1), 3'(s2), 4'd0};
  endfunction
  function automatic logic [15:0] ri(input int op, input int rd, input int s1, input int imm);
    return {3'(op), 3'(rd), 3'(s1), 7'(imm)};
  endfunction
  task automatic model(input logic [15:0] w);
    exp_t e;
    int op = int'(w[15:13]);
    int rd = int'(w[12:10]);
    int s1 = int'(w[9:7]);
    int s2 = int'(w[6:4]);
    int i7 = w[6] ? int'(w[6:0]) - 128 : int'(w[6:0]);
    int i10 = w[9] ? int'(w[9:0]) - 1024 : int'(w[9:0]);
    longint a = longint'(R[s1]);
    longint b = longint'(R[s2]);
    longint r;
    e.cyc = cyc + 3;
    e.addr = 3'(rd);
    e.disp = op == 7;
    e.chk_ops = op < 6;
    e.sel = 2'd0;
    if (op == 0) begin a = 0; b = i10; end
    if (op == 2 || op == 4) b = i7;
    if (op == 3 || op == 4) e.sel = 2'd1;
    if (op == 5) e.sel = 2'd2;
    r = e.sel == 2'd0 ? a + b : e.sel == 2'd1 ? a - b : a * b;
    e.a = 16'(a);
    e.b = 16'(b);
    if (op == 6) begin
      foreach (R[i]) R[i] = '0;
      e.data = '0;
    end else if (op == 7) e.data = R[s1];
    else begin
      e.data = 16'(r);
      R[rd] = e.data;
    end
    q.push_back(e);
  endtask
  // One clock of stimulus; cnt tracks how many cycles remain until the controller is free again.
  task automatic cycle(input logic v, input logic [15:0] w, input logic r);
    @(negedge clk);
    check("instr_ready", bus.instr_ready, cnt == 0);
    check("busy", bus.busy, cnt != 0);
    rst = r;
    bus.instr_valid = v;
    bus.instr = w;
    if (r) begin
      q.delete();
      cnt = 0;
      foreach (R[i]) R[i] = '0;
    end else if (cnt == 0 && v) begin
      model(w);
      cnt = 3;
    end else if (cnt > 0) cnt--;
  endtask
  task automatic issue(input logic [15:0] w);
    cycle(1'b1, w, 1'b0);
    repeat (3) cycle(1'b0, 16'($urandom), 1'b0);
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      check("pulse_missing", cyc, q[0].cyc);
      q.delete(0);
    end
    if (bus.wb_valid || bus.disp_valid) begin
      check("wb_disp_exclusive", bus.wb_valid && bus.disp_valid, 0);
      if (q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        me = q.pop_front();
        check("pulse_cycle", cyc, me.cyc);
        check("pulse_kind", bus.disp_valid, me.disp);
        if (me.disp) check("disp_data", bus.disp_data, me.data);
        else begin
          check("wb_addr", bus.wb_addr, me.addr);
          check("wb_data", bus.wb_data, me.data);
        end
        if (me.chk_ops) begin
          check("alu_data1", bus.alu_data1, me.a);
          check("alu_data2", bus.alu_data2, me.b);
          check("alu_sel", bus.alu_sel, me.sel);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [15:0] w;
    logic r;
    foreach (R[i]) R[i] = '0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    @(negedge clk);
    cycle(1'b1, ld(1, 5), 1'b1);
    cycle(1'b0, 16'd0, 1'b1);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_disp_valid", bus.disp_valid, 0);
    check("rst_wb_addr", bus.wb_addr, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_disp_data", bus.disp_data, 0);
    check("rst_alu_data1", bus.alu_data1, 0);
    check("rst_alu_data2", bus.alu_data2, 0);
    check("rst_alu_sel", bus.alu_sel, 0);
    issue(ld(1, 5));
    issue(ld(2, -3));
    issue(rr(1, 3, 1, 2));
    issue(ri(4, 4, 1, 7));
    issue(ld(1, 128));
    issue(rr(5, 1, 1, 1));
    issue(rr(1, 1, 1, 1));
    issue(ri(4, 1, 1, 1));
    issue(ld(2, 2));
    issue(rr(5, 5, 1, 2));
    issue(rr(1, 6, 1, 1));
    issue(rr(3, 2, 2, 1));
    issue(ri(2, 3, 3, -64));
    repeat (40) cycle(1'b1, 16'($urandom), 1'b0);
    while (cnt != 0) cycle(1'b0, 16'd0, 1'b0);
    issue(ld(2, 9));
    issue(rr(7, 0, 2, 0));
    cycle(1'b1, rr(1, 7, 1, 2), 1'b0);
    cycle(1'b0, 16'd0, 1'b0);
    cycle(1'b0, 16'd0, 1'b1);
    cycle(1'b0, 16'd0, 1'b0);
    issue(rr(7, 0, 7, 0));
    issue(ld(2, 9));
    issue(ld(5, -512));
    issue(rr(7, 0, 2, 0));
    issue(rr(6, 3, 0, 0));
    for (int i = 0; i < 8; i++) issue(rr(7, 0, i, 0));
    repeat (400) begin
      w = 16'($urandom);
      r = $urandom_range(0, 40) == 0 && cnt != 1;
      cycle($urandom_range(0, 2) != 0, w, r);
    end
    while (cnt != 0) cycle(1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 8; i++) issue(rr(7, 0, i, 0));
    repeat (4) cycle(1'b0, 16'd0, 1'b0);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
